game_state_ctrl: RTL and testbench
==================================

# game_state_ctrl

Game-flow sequencer producing the 3-bit `game_state` consumed by the overlay drawers: `draw_start` shows its banner in START, other drawers key on the remaining codes. It advances START → COUNTDOWN → PLAY → (PAUSE) → OVER → START on button edges, player-death flags and frame ticks derived from vsync. It also issues the round-reset pulse, countdown digit and winner code to the playfield and HUD logic.

## Interface
- `COUNT_FRAMES`, 60, frames per countdown digit; legal range 1..255.
- `OVER_FRAMES`, 120, minimum frames in OVER before `btn_start` is honoured; legal range 1..255.
- `clk`  in  1  pixel clock, same domain as the VGA pipeline.
- `rst`  in  1  synchronous, active-high reset.
- `vsync`  in  1  vsync from the VGA timing chain; each rising edge is one frame.
- `btn_start`  in  1  start button, already synchronised/debounced, level.
- `btn_pause`  in  1  pause button, already synchronised/debounced, level.
- `p1_dead`  in  1  player 1 eliminated, level.
- `p2_dead`  in  1  player 2 eliminated, level.
- `game_state`  out  3  current state code (registered).
- `countdown_val`  out  2  digit shown during COUNTDOWN (3,2,1); 0 otherwise.
- `winner`  out  2  01 = p1 won, 10 = p2 won, 11 = draw, 00 = none.
- `round_rst`  out  1  one-cycle pulse that resets playfield objects.
- `frame_tick`  out  1  one-cycle pulse per vsync rising edge.

## Operation
- Edge detection: `*_q` registers hold the previous sample; edge = `in & ~in_q`. All `*_q` registers reset to 1, so an input held high through reset produces no edge until it is released and pressed again.
- Frame counter: 8 bits, `frame_cnt`. It clears on every state entry and increments on `frame_tick`.
- START (000): a `btn_start` edge moves to COUNTDOWN. On that transition: `countdown_val` ← 3, `winner` ← 00, `round_rst` ← 1 for one cycle.
- COUNTDOWN (001): on a tick with `frame_cnt == COUNT_FRAMES-1`:
  - `frame_cnt` ← 0 and `countdown_val` decrements.
  - If `countdown_val` was 1, go to PLAY with `countdown_val` ← 0.
  - Buttons and death flags are ignored in this state.
- PLAY (010), priority order:
  - Any death flag → OVER, with `winner` = {`p1_dead`, `p2_dead`} mapped as p2_dead only → 01, p1_dead only → 10, both → 11.
  - Otherwise a `btn_pause` edge → PAUSE.
  - `btn_start` is ignored.
- PAUSE (011): a `btn_pause` edge → PLAY. Death flags and `btn_start` are ignored.
- OVER (100):
  - `frame_cnt` saturates at `OVER_FRAMES`.
  - A `btn_start` edge with `frame_cnt == OVER_FRAMES` → START.
  - A `btn_start` edge before that point is dropped, not latched.
  - `winner` holds its value until the next `round_rst`.
- Illegal codes 101–111 → START on the next cycle.
- Reset values: `game_state` = 000, `countdown_val` = 0, `winner` = 00, `round_rst` = 0, `frame_tick` = 0, `frame_cnt` = 0.
- Reset asserted mid-operation overrides all transitions in that cycle.

## Timing
- Input sampled high at edge k (previous sample low) → `game_state` / `round_rst` updated at edge k. Latency 1 clock from input change to output change.
- `frame_tick` is high for the one cycle following the edge at which `vsync` is first sampled high.
- A `frame_tick` in the same cycle as a state transition is consumed by the new state's counter clear and does not count.
- COUNTDOWN duration is exactly 3·`COUNT_FRAMES` ticks. PLAY is entered on the clock edge that samples the final tick.
- `round_rst` never coincides with any state other than the START→COUNTDOWN transition.

## Configuration
- `GAME_PAUSE_EN` defined: PAUSE state and `btn_pause` handling as described.
- `GAME_PAUSE_EN` undefined:
  - `btn_pause` is ignored and 011 is never produced.
  - 011 is treated as an illegal code (→ START).
  - The `btn_pause` port remains so that top-level wiring is unchanged.

## Structure
- `game_pkg` holds:
  - the state enum `game_state_t` (3-bit: `GS_START`=000, `GS_COUNTDOWN`=001, `GS_PLAY`=010, `GS_PAUSE`=011, `GS_OVER`=100);
  - the winner codes `WIN_NONE`, `WIN_P1`, `WIN_P2`, `WIN_DRAW`.
- Overlay drawers compare `game_state` against these package constants, not literals.
- Sub-module `edge_rise`:
  - one register plus AND;
  - reset value parameter `INIT`;
  - instantiated for `vsync` (`INIT`=1), `btn_start` and `btn_pause`.
- The FSM, frame counter and outputs live in `game_state_ctrl`.

## Test plan
- Hold `btn_start` high through reset, release reset → state stays 000; release and re-press → 001 one clock later, `round_rst` high for exactly 1 cycle, `countdown_val`=3.
- `COUNT_FRAMES`=2, drive 6 vsync pulses after entering COUNTDOWN → `countdown_val` sequence 3,3,2,2,1,1 per tick, state 010 on the 6th tick, `countdown_val`=0.
- In PLAY, assert `p1_dead` and `p2_dead` in the same cycle together with a `btn_pause` edge → state 100, `winner`=11 (death beats pause).
- In OVER with `OVER_FRAMES`=4: `btn_start` edge after 2 ticks → stays 100; edge after 4 ticks → 000, `winner` still 11 until the next start.
- With `GAME_PAUSE_EN`: in PLAY, `btn_pause` edge → 011; `p2_dead` high in 011 → no change; second pause edge → 010, then 100 with `winner`=01. Without the macro, the same stimulus → never 011.
- Assert `rst` for one cycle during COUNTDOWN (`countdown_val`=2) → next cycle state 000, `countdown_val`=0, `frame_cnt`=0, `winner`=00.

Source files
------------

// File: rtl/game_pkg.sv
// Shared state and winner encodings for the game-flow sequencer and the overlay drawers.
package game_pkg;

  typedef enum logic [2:0] {
    GS_START     = 3'b000,
    GS_COUNTDOWN = 3'b001,
    GS_PLAY      = 3'b010,
    GS_PAUSE     = 3'b011,
    GS_OVER      = 3'b100
  } game_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // The surviving player wins; simultaneous elimination is a draw.
  function automatic logic [1:0] winner_code(input logic p1_dead, input logic p2_dead);
    logic [1:0] code;
    code = WIN_NONE;
    if (p1_dead && p2_dead) code = WIN_DRAW;
    else if (p2_dead)       code = WIN_P1;
    else if (p1_dead)       code = WIN_P2;
    return code;
  endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// Player/video inputs and game-flow outputs of the sequencer.
interface game_state_ctrl_if;
  import game_pkg::*;

  logic        vsync;
  logic        btn_start;
  logic        btn_pause;
  logic        p1_dead;
  logic        p2_dead;
  game_state_t game_state;
  logic [1:0]  countdown_val;
  logic [1:0]  winner;
  logic        round_rst;
  logic        frame_tick;

  modport master (
    output vsync, btn_start, btn_pause, p1_dead, p2_dead,
    input  game_state, countdown_val, winner, round_rst, frame_tick
  );

  modport slave (
    input  vsync, btn_start, btn_pause, p1_dead, p2_dead,
    output game_state, countdown_val, winner, round_rst, frame_tick
  );

endinterface

// File: rtl/edge_rise.sv
// Rising-edge detector: one history register plus AND, reset to INIT.
module edge_rise #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) sig_q <= INIT;
    else     sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game-flow sequencer START -> COUNTDOWN -> PLAY -> (PAUSE) -> OVER -> START.
// Optional PAUSE state enabled by defining GAME_PAUSE_EN.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned COUNT_FRAMES = 60,
  parameter int unsigned OVER_FRAMES  = 120
) (
  input logic              clk,
  input logic              rst,
  game_state_ctrl_if.slave bus
);

  localparam logic [7:0] CountLast = 8'(COUNT_FRAMES - 1);
  localparam logic [7:0] OverSat   = 8'(OVER_FRAMES);

  game_state_t state_q;
  logic [1:0]  countdown_q;
  logic [1:0]  winner_q;
  logic        round_rst_q;
  logic        frame_tick_q;
  logic [7:0]  frame_cnt;

  logic vsync_rise;
  logic start_rise;
  logic pause_rise;
  logic pause_go;
  logic any_dead;

  edge_rise #(.INIT(1'b1)) u_vsync_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (bus.vsync),
    .rise (vsync_rise)
  );

  edge_rise #(.INIT(1'b1)) u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (bus.btn_start),
    .rise (start_rise)
  );

  edge_rise #(.INIT(1'b1)) u_pause_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (bus.btn_pause),
    .rise (pause_rise)
  );

`ifdef GAME_PAUSE_EN
  assign pause_go = pause_rise;
`else
  logic unused_pause_rise;
  assign unused_pause_rise = pause_rise;
  assign pause_go          = 1'b0;
`endif

  assign any_dead = bus.p1_dead | bus.p2_dead;

  // Every transition clears frame_cnt, so a tick landing on it is absorbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= GS_START;
      countdown_q  <= 2'd0;
      winner_q     <= WIN_NONE;
      round_rst_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      frame_cnt    <= 8'd0;
    end else begin
      frame_tick_q <= vsync_rise;
      round_rst_q  <= 1'b0;
      case (state_q)
        GS_START: begin
          if (start_rise) begin
            state_q     <= GS_COUNTDOWN;
            countdown_q <= 2'd3;
            winner_q    <= WIN_NONE;
            round_rst_q <= 1'b1;
            frame_cnt   <= 8'd0;
          end else if (frame_tick_q) begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        GS_COUNTDOWN: begin
          if (frame_tick_q) begin
            if (frame_cnt == CountLast) begin
              frame_cnt <= 8'd0;
              if (countdown_q == 2'd1) begin
                state_q     <= GS_PLAY;
                countdown_q <= 2'd0;
              end else begin
                countdown_q <= countdown_q - 2'd1;
              end
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        GS_PLAY: begin
          if (any_dead) begin
            state_q   <= GS_OVER;
            winner_q  <= winner_code(bus.p1_dead, bus.p2_dead);
            frame_cnt <= 8'd0;
          end else if (pause_go) begin
            state_q   <= GS_PAUSE;
            frame_cnt <= 8'd0;
          end else if (frame_tick_q) begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
`ifdef GAME_PAUSE_EN
        GS_PAUSE: begin
          if (pause_go) begin
            state_q   <= GS_PLAY;
            frame_cnt <= 8'd0;
          end else if (frame_tick_q) begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
`endif
        GS_OVER: begin
          // Early start presses are dropped rather than remembered.
          if (start_rise && frame_cnt == OverSat) begin
            state_q   <= GS_START;
            frame_cnt <= 8'd0;
          end else if (frame_tick_q && frame_cnt != OverSat) begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        default: begin
          state_q     <= GS_START;
          countdown_q <= 2'd0;
          frame_cnt   <= 8'd0;
        end
      endcase
    end
  end

  assign bus.game_state    = state_q;
  assign bus.countdown_val = countdown_q;
  assign bus.winner        = winner_q;
  assign bus.round_rst     = round_rst_q;
  assign bus.frame_tick    = frame_tick_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: vector table for the main flow, hand sequences for pause/reset.
module tb_game_state_ctrl;
  import game_pkg::*;

  typedef struct {
    logic       rst;
    logic       vsync;
    logic       start;
    logic       pause;
    logic       p1;
    logic       p2;
    logic [2:0] st;
    logic [1:0] cv;
    logic [1:0] win;
    logic       rr;
    logic       tick;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs[$];

  game_state_ctrl_if bus ();

  game_state_ctrl #(
    .COUNT_FRAMES (2),
    .OVER_FRAMES  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic s, input logic pa,
                     input logic p1, input logic p2, input logic [2:0] st,
                     input logic [1:0] cv, input logic [1:0] win, input logic rr,
                     input logic tk);
    vec_t x;
    x.rst = r; x.vsync = v; x.start = s; x.pause = pa; x.p1 = p1; x.p2 = p2;
    x.st = st; x.cv = cv; x.win = win; x.rr = rr; x.tick = tk;
    vecs.push_back(x);
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    bus.vsync = 1'b1;
    clk_step();
    bus.vsync = 1'b0;
    clk_step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst           = 1'b1;
    bus.vsync     = 1'b0;
    bus.btn_start = 1'b1;
    bus.btn_pause = 1'b0;
    bus.p1_dead   = 1'b0;
    bus.p2_dead   = 1'b0;

    //  rst v  st pa p1 p2  state cv win rr tick
    add(1, 0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0);   // r0 reset, start held
    add(1, 0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0);   // held through reset: no edge
    add(0, 0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 3'd1, 3, 0, 1, 0);   // r5 press -> COUNTDOWN
    add(0, 0, 1, 0, 0, 0, 3'd1, 3, 0, 0, 0);   // round_rst only one cycle
    add(0, 0, 0, 0, 0, 0, 3'd1, 3, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 3'd1, 3, 0, 0, 1);   // frame 1
    add(0, 0, 0, 0, 0, 0, 3'd1, 3, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 3'd1, 3, 0, 0, 1);   // frame 2
    add(0, 0, 0, 0, 0, 0, 3'd1, 2, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 3'd1, 2, 0, 0, 1);   // frame 3
    add(0, 0, 0, 0, 0, 0, 3'd1, 2, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 3'd1, 2, 0, 0, 1);   // frame 4
    add(0, 0, 0, 0, 0, 0, 3'd1, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 3'd1, 1, 0, 0, 1);   // frame 5
    add(0, 0, 0, 0, 0, 0, 3'd1, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 3'd1, 1, 0, 0, 1);   // frame 6
    add(0, 0, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0);   // PLAY
    add(0, 0, 0, 1, 1, 1, 3'd4, 0, 3, 0, 0);   // r20 death beats pause
    add(0, 0, 0, 0, 0, 0, 3'd4, 0, 3, 0, 0);
    add(0, 1, 0, 0, 0, 0, 3'd4, 0, 3, 0, 1);   // OVER frame 1
    add(0, 0, 0, 0, 0, 0, 3'd4, 0, 3, 0, 0);
    add(0, 1, 0, 0, 0, 0, 3'd4, 0, 3, 0, 1);   // OVER frame 2
    add(0, 0, 0, 0, 0, 0, 3'd4, 0, 3, 0, 0);
    add(0, 0, 1, 0, 0, 0, 3'd4, 0, 3, 0, 0);   // r26 early start dropped
    add(0, 0, 0, 0, 0, 0, 3'd4, 0, 3, 0, 0);
    add(0, 1, 0, 0, 0, 0, 3'd4, 0, 3, 0, 1);   // OVER frame 3
    add(0, 0, 0, 0, 0, 0, 3'd4, 0, 3, 0, 0);
    add(0, 1, 0, 0, 0, 0, 3'd4, 0, 3, 0, 1);   // OVER frame 4
    add(0, 0, 0, 0, 0, 0, 3'd4, 0, 3, 0, 0);
    add(0, 1, 0, 0, 0, 0, 3'd4, 0, 3, 0, 1);   // frame 5: counter saturated
    add(0, 0, 0, 0, 0, 0, 3'd4, 0, 3, 0, 0);
    add(0, 0, 1, 0, 0, 0, 3'd0, 0, 3, 0, 0);   // r34 -> START, winner kept
    add(0, 0, 0, 0, 0, 0, 3'd0, 0, 3, 0, 0);
    add(0, 0, 1, 0, 0, 0, 3'd1, 3, 0, 1, 0);   // r36 new round clears winner

    foreach (vecs[i]) begin
      rst           = vecs[i].rst;
      bus.vsync     = vecs[i].vsync;
      bus.btn_start = vecs[i].start;
      bus.btn_pause = vecs[i].pause;
      bus.p1_dead   = vecs[i].p1;
      bus.p2_dead   = vecs[i].p2;
      clk_step();
      chk($sformatf("row%0d game_state", i), int'(bus.game_state), int'(vecs[i].st));
      chk($sformatf("row%0d countdown_val", i), int'(bus.countdown_val), int'(vecs[i].cv));
      chk($sformatf("row%0d winner", i), int'(bus.winner), int'(vecs[i].win));
      chk($sformatf("row%0d round_rst", i), int'(bus.round_rst), int'(vecs[i].rr));
      chk($sformatf("row%0d frame_tick", i), int'(bus.frame_tick), int'(vecs[i].tick));
    end

    // Pause handling from a fresh countdown.
    bus.btn_start = 1'b0;
    repeat (6) frame();
    chk("pause_seq play", int'(bus.game_state), int'(GS_PLAY));
    bus.btn_pause = 1'b1;
    clk_step();
    bus.btn_pause = 1'b0;
`ifdef GAME_PAUSE_EN
    chk("pause_seq paused", int'(bus.game_state), int'(GS_PAUSE));
    bus.p2_dead = 1'b1;
    clk_step();
    chk("pause_seq death ignored", int'(bus.game_state), int'(GS_PAUSE));
    bus.p2_dead = 1'b0;
    clk_step();
    bus.btn_pause = 1'b1;
    clk_step();
    bus.btn_pause = 1'b0;
    chk("pause_seq resumed", int'(bus.game_state), int'(GS_PLAY));
    bus.p2_dead = 1'b1;
    clk_step();
`else
    chk("pause_seq no pause", int'(bus.game_state), int'(GS_PLAY));
    bus.p2_dead = 1'b1;
    clk_step();
`endif
    bus.p2_dead = 1'b0;
    chk("pause_seq over", int'(bus.game_state), int'(GS_OVER));
    chk("pause_seq winner p1", int'(bus.winner), int'(WIN_P1));

    // Reset during countdown.
    repeat (4) frame();
    bus.btn_start = 1'b1;
    clk_step();
    bus.btn_start = 1'b0;
    chk("rst_seq start", int'(bus.game_state), int'(GS_START));
    clk_step();
    bus.btn_start = 1'b1;
    clk_step();
    bus.btn_start = 1'b0;
    chk("rst_seq countdown", int'(bus.game_state), int'(GS_COUNTDOWN));
    chk("rst_seq round_rst", int'(bus.round_rst), 1);
    repeat (3) frame();
    chk("rst_seq cv2", int'(bus.countdown_val), 2);
    chk("rst_seq frame_cnt before", int'(dut.frame_cnt), 1);
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    chk("rst_seq state", int'(bus.game_state), int'(GS_START));
    chk("rst_seq cv", int'(bus.countdown_val), 0);
    chk("rst_seq winner", int'(bus.winner), int'(WIN_NONE));
    chk("rst_seq frame_cnt", int'(dut.frame_cnt), 0);
    chk("rst_seq round_rst", int'(bus.round_rst), 0);
    clk_step();
    chk("rst_seq stays start", int'(bus.game_state), int'(GS_START));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
